// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM states and event record for the PS/2 key event path.
package ps2_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_F0 = 8'hF0;

   // Modifier and lock make codes
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_NUM    = 8'h77;

   // Bytes after a Pause (E1) prefix that are swallowed
   localparam logic [2:0] SKIP_LEN = 3'd7;

   typedef enum logic [2:0] {
      StIdle,
      StExt,
      StBrk,
      StExtBrk,
      StSkip
   } ps2_state_e;

   // Event record; mods = {caps_lock, ctrl, alt, shift}
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rpt;
      logic [3:0] mods;
   } ps2_event_t;

   localparam int unsigned EV_W = $bits(ps2_event_t);

   // Keyboard status/ack bytes that never carry key information
   function automatic logic is_discard(logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; head is read from registers, so no input-to-output path.
module ps2_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [AW-1:0]    rd_idx, last_idx;
   logic             do_push, do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop   = pop && !empty;
   // Push into a full FIFO only succeeds when the head leaves in the same cycle
   assign do_push  = push && (!full || do_pop);
   assign rd_idx   = rd_ptr_q[AW-1:0];
   assign last_idx = rd_idx - AW'(1);
   // When empty, keep presenting the most recently popped entry
   assign rdata    = empty ? mem_q[last_idx] : mem_q[rd_idx];

   // Storage and pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the raw PS/2 scan-code byte stream into buffered key events plus modifier state.
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 2000000,
   parameter int unsigned PASS_REPEAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       code_valid,
   input  logic [7:0] code_byte,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_repeat,
   output logic [3:0] ev_mods,
   output logic       held,
   output logic [7:0] cur_code,
   output logic [7:0] prev_code,
   output logic [7:0] key_count,
   output logic       shift,
   output logic       ctrl,
   output logic       alt,
   output logic       caps_lock,
   output logic       num_lock,
   output logic       overflow
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

   ps2_state_e state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic shl_q, shl_d, shr_q, shr_d, ctrl_q, ctrl_d, alt_q, alt_d;
   logic caps_q, caps_d, num_q, num_d, caps_held_q, caps_held_d, num_held_q, num_held_d;
   logic held_q, held_d, held_ext_q, held_ext_d, ovf_q, ovf_d;
   logic [7:0] cur_q, cur_d, prev_q, prev_d, kc_q, kc_d;

   logic       do_make, do_break, key_ext, push_req;
   ps2_event_t push_ev, head_ev;
   logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [3:0] mods_now;

   assign mods_now  = {caps_q, ctrl_q, alt_q, shl_q | shr_q};
   assign fifo_pop  = !fifo_empty && ev_ready;
   assign fifo_push = push_req && (!fifo_full || fifo_pop);

   // Prefix FSM, timeout, key tracking and event generation
   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      tmo_d       = tmo_q;
      shl_d       = shl_q;
      shr_d       = shr_q;
      ctrl_d      = ctrl_q;
      alt_d       = alt_q;
      caps_d      = caps_q;
      num_d       = num_q;
      caps_held_d = caps_held_q;
      num_held_d  = num_held_q;
      held_d      = held_q;
      held_ext_d  = held_ext_q;
      cur_d       = cur_q;
      prev_d      = prev_q;
      kc_d        = kc_q;
      ovf_d       = ovf_q;
      do_make     = 1'b0;
      do_break    = 1'b0;
      key_ext     = 1'b0;
      push_req    = 1'b0;
      push_ev     = '{code: code_byte, ext: 1'b0, rpt: 1'b0, mods: mods_now};

      if (code_valid) begin
         tmo_d = '0;
         unique case (state_q)
            StIdle: begin
               if (code_byte == SC_E0) state_d = StExt;
               else if (code_byte == SC_F0) state_d = StBrk;
               else if (code_byte == SC_E1) begin
                  state_d = StSkip;
                  skip_d  = SKIP_LEN;
               end else if (!is_discard(code_byte)) do_make = 1'b1;
            end
            StExt: begin
               state_d = StIdle;
               if (code_byte == SC_F0) state_d = StExtBrk;
               else if (code_byte != SC_E0 && code_byte != SC_LSHIFT) begin
                  do_make = 1'b1;
                  key_ext = 1'b1;
               end
            end
            StBrk: begin
               state_d  = StIdle;
               do_break = 1'b1;
            end
            StExtBrk: begin
               state_d  = StIdle;
               do_break = 1'b1;
               key_ext  = 1'b1;
            end
            StSkip: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  state_d  = StIdle;
                  kc_d     = kc_q + 8'd1;
                  push_req = 1'b1;
                  push_ev  = '{code: SC_E1, ext: 1'b0, rpt: 1'b0, mods: mods_now};
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle) begin
         // Abandon a prefix sequence whose remaining bytes never arrived
         if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = StIdle;
            skip_d  = '0;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      if (do_make) begin
         push_ev.ext = key_ext;
         if (code_byte == SC_LSHIFT) shl_d = 1'b1;
         else if (code_byte == SC_RSHIFT) shr_d = 1'b1;
         else if (code_byte == SC_CTRL) ctrl_d = 1'b1;
         else if (code_byte == SC_ALT) alt_d = 1'b1;
         else if (code_byte == SC_CAPS) begin
            // Toggle only on the first make; typematic repeats leave the lock alone
            if (!caps_held_q) caps_d = ~caps_q;
            caps_held_d = 1'b1;
         end else if (code_byte == SC_NUM && !key_ext) begin
            if (!num_held_q) num_d = ~num_q;
            num_held_d = 1'b1;
         end else if (held_q && held_ext_q == key_ext && cur_q == code_byte) begin
            if (PASS_REPEAT != 0) begin
               push_req    = 1'b1;
               push_ev.rpt = 1'b1;
            end
         end else begin
            prev_d     = cur_q;
            cur_d      = code_byte;
            kc_d       = kc_q + 8'd1;
            held_d     = 1'b1;
            held_ext_d = key_ext;
            push_req   = 1'b1;
         end
      end

      if (do_break) begin
         if (code_byte == SC_LSHIFT) shl_d = 1'b0;
         else if (code_byte == SC_RSHIFT) shr_d = 1'b0;
         else if (code_byte == SC_CTRL) ctrl_d = 1'b0;
         else if (code_byte == SC_ALT) alt_d = 1'b0;
         else if (code_byte == SC_CAPS) caps_held_d = 1'b0;
         else if (code_byte == SC_NUM && !key_ext) num_held_d = 1'b0;
         else if (held_q && held_ext_q == key_ext && cur_q == code_byte) held_d = 1'b0;
      end

      if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         skip_q      <= '0;
         tmo_q       <= '0;
         shl_q       <= 1'b0;
         shr_q       <= 1'b0;
         ctrl_q      <= 1'b0;
         alt_q       <= 1'b0;
         caps_q      <= 1'b0;
         num_q       <= 1'b0;
         caps_held_q <= 1'b0;
         num_held_q  <= 1'b0;
         held_q      <= 1'b0;
         held_ext_q  <= 1'b0;
         cur_q       <= '0;
         prev_q      <= '0;
         kc_q        <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         tmo_q       <= tmo_d;
         shl_q       <= shl_d;
         shr_q       <= shr_d;
         ctrl_q      <= ctrl_d;
         alt_q       <= alt_d;
         caps_q      <= caps_d;
         num_q       <= num_d;
         caps_held_q <= caps_held_d;
         num_held_q  <= num_held_d;
         held_q      <= held_d;
         held_ext_q  <= held_ext_d;
         cur_q       <= cur_d;
         prev_q      <= prev_d;
         kc_q        <= kc_d;
         ovf_q       <= ovf_d;
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (push_ev),
      .pop   (fifo_pop),
      .rdata (head_ev),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_valid  = !fifo_empty;
   assign ev_code   = head_ev.code;
   assign ev_ext    = head_ev.ext;
   assign ev_repeat = head_ev.rpt;
   assign ev_mods   = head_ev.mods;
   assign held      = held_q;
   assign cur_code  = cur_q;
   assign prev_code = prev_q;
   assign key_count = kc_q;
   assign shift     = shl_q | shr_q;
   assign ctrl      = ctrl_q;
   assign alt       = alt_q;
   assign caps_lock = caps_q;
   assign num_lock  = num_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench: two instances (repeats dropped / passed) share one byte stream.
module tb_ps2_key_event_ctrl;

   localparam int unsigned T = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code_byte = 8'h00;
   logic       ev_ready = 1'b0;

   logic       a_ev_valid, a_ev_ext, a_ev_repeat, a_held, a_shift, a_ctrl, a_alt;
   logic       a_caps, a_num, a_ovf;
   logic [7:0] a_ev_code, a_cur, a_prev, a_kc;
   logic [3:0] a_ev_mods;
   logic       b_ev_valid, b_ev_ext, b_ev_repeat, b_held, b_shift, b_ctrl, b_alt;
   logic       b_caps, b_num, b_ovf;
   logic [7:0] b_ev_code, b_cur, b_prev, b_kc;
   logic [3:0] b_ev_mods;

   int total = 0;
   int bad = 0;
   logic [13:0] qa[$];
   logic [13:0] qb[$];

   always #5 clk = ~clk;

   ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T), .PASS_REPEAT(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_byte(code_byte),
      .ev_valid(a_ev_valid), .ev_ready(ev_ready), .ev_code(a_ev_code), .ev_ext(a_ev_ext),
      .ev_repeat(a_ev_repeat), .ev_mods(a_ev_mods), .held(a_held), .cur_code(a_cur),
      .prev_code(a_prev), .key_count(a_kc), .shift(a_shift), .ctrl(a_ctrl), .alt(a_alt),
      .caps_lock(a_caps), .num_lock(a_num), .overflow(a_ovf)
   );

   ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T), .PASS_REPEAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_byte(code_byte),
      .ev_valid(b_ev_valid), .ev_ready(ev_ready), .ev_code(b_ev_code), .ev_ext(b_ev_ext),
      .ev_repeat(b_ev_repeat), .ev_mods(b_ev_mods), .held(b_held), .cur_code(b_cur),
      .prev_code(b_prev), .key_count(b_kc), .shift(b_shift), .ctrl(b_ctrl), .alt(b_alt),
      .caps_lock(b_caps), .num_lock(b_num), .overflow(b_ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: a pop happens at the next rising edge, so compare the head now
   always @(negedge clk) begin
      if (rst_n && a_ev_valid && ev_ready) begin
         if (qa.size() == 0) chk("unexpected_ev_a", {a_ev_code, a_ev_ext, a_ev_repeat, a_ev_mods}, 32'hFFFF_FFFF);
         else chk("ev_a", {a_ev_code, a_ev_ext, a_ev_repeat, a_ev_mods}, qa.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_ev_valid && ev_ready) begin
         if (qb.size() == 0) chk("unexpected_ev_b", {b_ev_code, b_ev_ext, b_ev_repeat, b_ev_mods}, 32'hFFFF_FFFF);
         else chk("ev_b", {b_ev_code, b_ev_ext, b_ev_repeat, b_ev_mods}, qb.pop_front());
      end
   end

   task automatic exp_ev(input logic [7:0] c, input logic e, input logic r, input logic [3:0] m,
                         input bit to_a, input bit to_b);
      if (to_a) qa.push_back({c, e, r, m});
      if (to_b) qb.push_back({c, e, r, m});
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      code_valid = 1'b1;
      code_byte  = b;
      @(posedge clk); #1;
      code_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({name, "_left_a"}, qa.size(), 0);
      chk({name, "_left_b"}, qb.size(), 0);
   endtask

   task automatic do_reset();
      ev_ready = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      #10;
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst_ev_valid", a_ev_valid, 0);
      chk("rst_kc", a_kc, 8'h00);
      chk("rst_cur", a_cur, 8'h00);
      chk("rst_mods", {a_held, a_shift, a_ctrl, a_alt, a_caps, a_num, a_ovf}, 0);
      rst_n = 1'b1;
      idle(2);

      // Single key press and release; status bytes discarded
      ev_ready = 1'b1;
      exp_ev(8'h1C, 0, 0, 4'b0000, 1, 1);
      send(8'hAA); send(8'hFA); send(8'h00);
      chk("discard_kc", a_kc, 8'h00);
      send(8'h1C);
      chk("t1_held", a_held, 1);
      chk("t1_cur", a_cur, 8'h1C);
      chk("t1_prev", a_prev, 8'h00);
      chk("t1_kc", a_kc, 8'h01);
      send(8'hF0); send(8'h1C);
      chk("t1_held_rel", a_held, 0);
      drain("t1");

      // Typematic repeats
      do_reset();
      ev_ready = 1'b1;
      exp_ev(8'h1C, 0, 0, 4'b0000, 1, 1);
      exp_ev(8'h1C, 0, 1, 4'b0000, 0, 1);
      exp_ev(8'h1C, 0, 1, 4'b0000, 0, 1);
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      chk("t2_kc_a", a_kc, 8'h01);
      chk("t2_kc_b", b_kc, 8'h01);
      drain("t2");

      // Shift modifier and caps lock toggling
      do_reset();
      ev_ready = 1'b1;
      exp_ev(8'h1C, 0, 0, 4'b0001, 1, 1);
      send(8'h12);
      chk("t3_shift", a_shift, 1);
      send(8'h1C);
      send(8'hF0); send(8'h12);
      chk("t3_shift_rel", a_shift, 0);
      send(8'h58);
      chk("t3_caps1", a_caps, 1);
      send(8'hF0); send(8'h58);
      chk("t3_caps2", a_caps, 1);
      send(8'h58);
      chk("t3_caps3", a_caps, 0);
      chk("t3_held", a_held, 1);
      chk("t3_cur", a_cur, 8'h1C);
      drain("t3");

      // Extended key then Pause sequence
      do_reset();
      ev_ready = 1'b1;
      exp_ev(8'h75, 1, 0, 4'b0000, 1, 1);
      exp_ev(8'hE1, 0, 0, 4'b0000, 1, 1);
      exp_ev(8'h1C, 0, 0, 4'b0000, 1, 1);
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      chk("t4_held_rel", a_held, 0);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("t4_kc", a_kc, 8'h02);
      chk("t4_ctrl_num", {a_ctrl, a_num}, 2'b00);
      send(8'h1C);
      chk("t4_kc_idle", a_kc, 8'h03);
      drain("t4");

      // FIFO overflow, then drain in order
      do_reset();
      exp_ev(8'h15, 0, 0, 4'b0000, 1, 1);
      exp_ev(8'h1D, 0, 0, 4'b0000, 1, 1);
      exp_ev(8'h24, 0, 0, 4'b0000, 1, 1);
      exp_ev(8'h2D, 0, 0, 4'b0000, 1, 1);
      send(8'h15);
      chk("t5_latency", a_ev_valid, 1);
      send(8'h1D); send(8'h24); send(8'h2D);
      chk("t5_ovf_before", a_ovf, 0);
      send(8'h2C);
      chk("t5_ovf", a_ovf, 1);
      chk("t5_kc", a_kc, 8'h05);
      chk("t5_cur", a_cur, 8'h2C);
      ev_ready = 1'b1;
      drain("t5");
      idle(2);
      chk("t5_empty", a_ev_valid, 0);
      chk("t5_hold_code", a_ev_code, 8'h2D);
      chk("t5_ovf_sticky", a_ovf, 1);

      // Prefix timeout boundary
      do_reset();
      ev_ready = 1'b1;
      exp_ev(8'h75, 1, 0, 4'b0000, 1, 1);
      exp_ev(8'h1C, 0, 0, 4'b0000, 1, 1);
      send(8'hE0); idle(T - 5); send(8'h75);
      send(8'hE0); idle(T); send(8'h1C);
      chk("t6_kc", a_kc, 8'h02);
      drain("t6");

      // Asynchronous reset with events queued
      do_reset();
      send(8'h1C); send(8'h1B);
      chk("t7_queued", a_ev_valid, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      #1;
      chk("t7_ev_valid", a_ev_valid, 0);
      chk("t7_kc", a_kc, 8'h00);
      chk("t7_cur_prev", {a_cur, a_prev}, 16'h0000);
      chk("t7_held", a_held, 0);
      #10;
      rst_n = 1'b1;
      idle(3);
      chk("t7_still_empty", a_ev_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
Sequences the raw PS/2 scan-code byte stream into discrete key events. Sits between the PS2Receiver byte output (one pulse per byte) and its consumers: scancode_to_ascii, the seven-segment data mux and the LEDs. It decodes the E0/F0/E1 prefixes, suppresses typematic repeats, tracks modifier and lock state, counts key presses and buffers events in a small FIFO with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 2
TIMEOUT_CYC, 2000000, idle clk cycles after which a partial prefix sequence is abandoned (40 ms at 50 MHz)
PASS_REPEAT, 0, 1 = enqueue typematic repeats with ev_repeat=1; 0 = drop them

Ports:
clk  in  1  system clock, 50 MHz domain; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
code_valid  in  1  single-cycle strobe: code_byte holds one complete received byte
code_byte  in  8  received scan-code byte
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts the head event; a pop occurs on ev_valid && ev_ready
ev_code  out  8  make code of the head event
ev_ext  out  1  head event was E0-prefixed
ev_repeat  out  1  head event is a typematic repeat
ev_mods  out  4  {caps_lock, ctrl, alt, shift} sampled when the event was enqueued
held  out  1  a non-modifier key is currently held
cur_code  out  8  most recent new make code, non-modifier
prev_code  out  8  cur_code value before its last update
key_count  out  8  count of new make events; wraps from FF to 00
shift, ctrl, alt, caps_lock, num_lock  out  1 each  modifier and lock state
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: FSM=IDLE. Outputs ev_valid, held, all modifier and lock outputs, and overflow are 0. cur_code, prev_code and key_count are 00. FIFO is empty. Timeout and skip counters are 0.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (Pause sequence). The FSM advances only on code_valid.
- IDLE transitions: E0->EXT; F0->BRK; E1->SKIP with skip_cnt=7; other codes: make handling, FSM stays in IDLE.
- EXT transitions: F0->EXT_BRK; E0 and 12 (fake shift) are discarded and go to IDLE; other codes: make with ext=1, then IDLE.
- BRK and EXT_BRK: the byte is the break code; break handling, then IDLE.
- SKIP: each byte decrements skip_cnt. On reaching 0, one event {code=E1, ext=0} is enqueued, key_count increments, and the FSM returns to IDLE.
- In IDLE, the bytes 00, AA, EE, FA, FE and FF are discarded with no state change.
- Timeout: a counter clears on every code_valid and increments while the FSM is not IDLE. At TIMEOUT_CYC-1 the FSM goes to IDLE and skip_cnt clears. No event is generated.
- Make handling:
  - 12 and 59 set the left and right shift bits; shift is their OR. 14 sets ctrl (ext or not). 11 sets alt (ext or not).
  - 58 toggles caps_lock; 77 with ext=0 toggles num_lock. A toggle happens only on the first make, not on repeats. The lock keys are tracked in a separate latch; they do not affect held or cur_code.
  - Modifier and lock keys are never enqueued.
  - Other keys, if held=1 and {ext,code} equals the held key: repeat. It is enqueued only if PASS_REPEAT=1, and then with ev_repeat=1. key_count and cur_code are unchanged.
  - Other keys, otherwise: new press. prev_code<=cur_code, cur_code<=code, key_count+=1, held<=1, and an event is enqueued with ev_repeat=0.
- Break handling:
  - A modifier break clears its bit.
  - A break matching the held {ext,code} clears held.
  - Other breaks are ignored.
  - Breaks are never enqueued.
- Latency: code_valid at edge n; state and outputs updated at n+1; ev_valid rises at n+1 when the FIFO was empty (registered head, no combinational path from code_valid).
- FIFO full, push with no pop in the same cycle: the event is dropped and overflow<=1. key_count and cur_code still update.
- FIFO full, push and pop in the same cycle: both take effect; the FIFO stays full and no overflow is flagged.
- FIFO empty: ev_ready is ignored and ev_code and ev_mods hold their last value.
- Pointer wrap is modulo FIFO_DEPTH, with an extra bit for the full/empty distinction.
- Reset asserted mid-sequence or with events queued: everything returns to reset values immediately; queued events are lost.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants: E0, E1, F0, L/R shift, ctrl, alt, caps, num, and the discard set
  - FSM state enum
  - event record {code[7:0], ext, repeat, mods[3:0]}: 14 bits
- One sub-module: ps2_evt_fifo, a synchronous FIFO with parameterised depth and width=14 and a push/pop/full/empty interface; the controller instantiates it.

Test Plan:
- Bytes 1C, F0 1C (ev_ready=1) -> one event {1C,ext0,rep0,mods0}; key_count 00->01; held 1->0; cur_code=1C, prev_code=00.
- 1C 1C 1C F0 1C with PASS_REPEAT=0 -> exactly one event; key_count=01. The same stimulus with PASS_REPEAT=1 -> three events: rep=0, rep=1, rep=1.
- 12 (make), 1C, F0 12, 58, F0 58, 58 -> event 1C with mods=0001; shift=0 after F0 12; caps_lock 0->1->1->0 (second 58 toggles back).
- E0 75, E0 F0 75, then E1 14 77 E1 F0 14 F0 77 -> event {75,ext1}; then exactly one event {E1,ext0}; key_count=02; FSM back in IDLE.
- FIFO_DEPTH=4, ev_ready=0, five distinct makes -> four events held, overflow=1, key_count=05. Then ev_ready=1 -> pops return the first four codes in order and ev_valid deasserts.
- E0 then silence for TIMEOUT_CYC cycles, then 1C -> FSM back in IDLE; event {1C,ext0}. Separately, rst_n pulsed low mid-queue -> ev_valid=0 and all counters 00 without waiting for a clk edge.
